scene_display: RTL and testbench

//  Procedural background renderer for the runner-game scene band (640x480 raster, rows 20..99).

---
 rtl/scene_pkg.sv | 32 +++
 rtl/tick_sync.sv | 27 ++
 rtl/scene_display.sv | 85 ++++++++
 tb/tb_scene_display.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/scene_pkg.sv
// rtl/scene_pkg.sv - shared colours, scene geometry and game_state encoding
package scene_pkg;

    localparam logic [11:0] COL_SKY   = 12'hFFF;
    localparam logic [11:0] COL_GND   = 12'h555;
    localparam logic [11:0] COL_CLOUD = 12'hDDD;

    localparam logic [9:0] X_MAX = 10'd639;

    // Rows are relative to the first row of the scene band
    localparam logic [8:0] HORIZON_R = 9'd60;
    localparam logic [8:0] PEBBLE_R0 = 9'd64;
    localparam logic [8:0] PEBBLE_R1 = 9'd70;

    localparam logic [9:0] CLA_X0 = 10'd100;
    localparam logic [9:0] CLA_X1 = 10'd147;
    localparam logic [8:0] CLA_R0 = 9'd8;
    localparam logic [8:0] CLA_R1 = 9'd19;

    localparam logic [9:0] CLB_X0 = 10'd500;
    localparam logic [9:0] CLB_X1 = 10'd563;
    localparam logic [8:0] CLB_R0 = 9'd24;
    localparam logic [8:0] CLB_R1 = 9'd35;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_OVER    = 2'd2,
        ST_RESTART = 2'd3
    } game_state_t;

endpackage

// File: rtl/tick_sync.sv
// rtl/tick_sync.sv - two-flop synchroniser with a one-cycle rising-edge pulse
module tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/scene_display.sv
// rtl/scene_display.sv - procedural scene background: sky, scrolling clouds, horizon, pebbles
module scene_display
    import scene_pkg::*;
#(
    parameter int SPEED    = 2,
    parameter int SCENE_Y0 = 20,
    parameter int SCENE_H  = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_100Hz,
    input  logic [8:0]  y,
    input  logic [9:0]  x,
    input  logic [1:0]  game_state,
    output logic [11:0] data
);

    localparam logic [9:0] SPEED_V = 10'(SPEED);
    localparam logic [8:0] Y_FIRST = 9'(SCENE_Y0);
    localparam logic [8:0] Y_END   = 9'(SCENE_Y0 + SCENE_H);

    logic       tick;
    logic [9:0] gnd_off;
    logic [9:0] cld_off;
    logic       cld_div;

    tick_sync u_tick_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .level (clk_100Hz),
        .pulse (tick)
    );

    // Clouds advance on every second tick, giving parallax against the ground
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnd_off <= '0;
            cld_off <= '0;
            cld_div <= 1'b0;
        end else if (game_state == ST_RESTART) begin
            gnd_off <= '0;
            cld_off <= '0;
            cld_div <= 1'b0;
        end else if (tick && game_state == ST_RUN) begin
            gnd_off <= gnd_off + SPEED_V;
            cld_div <= ~cld_div;
            if (cld_div) begin
                cld_off <= cld_off + 10'd1;
            end
        end
    end

    logic [8:0]  r;
    logic [9:0]  wx;
    logic [9:0]  cx;
    logic [11:0] colour;

    always_comb begin
        r      = y - Y_FIRST;
        wx     = x + gnd_off;
        cx     = x + cld_off;
        colour = COL_SKY;
        if (y < Y_FIRST || y >= Y_END || x > X_MAX) begin
            colour = COL_SKY;
        end else if (r == HORIZON_R) begin
            colour = COL_GND;
        end else if ((r == PEBBLE_R0 && (wx[6:0] == 7'd0 || wx[6:0] == 7'd37)) ||
                     (r == PEBBLE_R1 && wx[5:0] == 6'd17)) begin
            colour = COL_GND;
        end else if (cx >= CLA_X0 && cx <= CLA_X1 && r >= CLA_R0 && r <= CLA_R1) begin
            colour = COL_CLOUD;
        end else if (cx >= CLB_X0 && cx <= CLB_X1 && r >= CLB_R0 && r <= CLB_R1) begin
            colour = COL_CLOUD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= COL_SKY;
        end else begin
            data <= colour;
        end
    end

endmodule

// File: tb/tb_scene_display.sv
// tb/tb_scene_display.sv - directed vector bench for scene_display
module tb_scene_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_100Hz;
    logic [8:0]  y_i;
    logic [9:0]  x_i;
    logic [1:0]  gs;
    logic [11:0] data;

    int checks   = 0;
    int failures = 0;

    scene_display #(.SPEED(2), .SCENE_Y0(20), .SCENE_H(80)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_100Hz  (clk_100Hz),
        .y          (y_i),
        .x          (x_i),
        .game_state (gs),
        .data       (data)
    );

    always #2 clk = ~clk;

    typedef struct {
        int          ph;
        int          x;
        int          y;
        logic [11:0] exp;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    task automatic check(input string name, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_px(input int px, input int py, input logic [11:0] exp, input string tag);
        @(posedge clk); #1;
        x_i = 10'(px);
        y_i = 9'(py);
        @(posedge clk); #1;
        check($sformatf("%s_x%0d_y%0d", tag, px, py), data, exp);
    endtask

    task automatic run_phase(input int p);
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].ph == p) check_px(tbl[i].x, tbl[i].y, tbl[i].exp, $sformatf("ph%0d", p));
        end
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 clk_100Hz = 1'b1;
            repeat (3) @(posedge clk);
            #1 clk_100Hz = 1'b0;
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic restart_pulse();
        @(posedge clk); #1 gs = 2'd3;
        @(posedge clk); #1 gs = 2'd1;
    endtask

    initial begin
        // phase 1: just out of reset; phase 2: offsets zero
        tbl[0]  = '{1, 0,   80, 12'h555};
        tbl[1]  = '{1, 5,   50, 12'hFFF};
        tbl[2]  = '{2, 0,   84, 12'h555};
        tbl[3]  = '{2, 100, 28, 12'hDDD};
        tbl[4]  = '{2, 99,  28, 12'hFFF};
        tbl[5]  = '{2, 300, 10, 12'hFFF};
        tbl[6]  = '{2, 37,  84, 12'h555};
        tbl[7]  = '{2, 17,  90, 12'h555};
        tbl[8]  = '{2, 81,  90, 12'h555};
        tbl[9]  = '{2, 700, 80, 12'hFFF};
        tbl[10] = '{2, 0,  100, 12'hFFF};
        tbl[11] = '{2, 0,   19, 12'hFFF};
        tbl[12] = '{2, 639, 80, 12'h555};
        tbl[13] = '{2, 147, 39, 12'hDDD};
        tbl[14] = '{2, 148, 39, 12'hFFF};
        tbl[15] = '{2, 500, 44, 12'hDDD};
        tbl[16] = '{2, 563, 55, 12'hDDD};
        tbl[17] = '{2, 564, 55, 12'hFFF};
        tbl[18] = '{2, 500, 56, 12'hFFF};
        // phase 3: gnd_off=10, cld_off=2
        tbl[19] = '{3, 118, 84, 12'h555};
        tbl[20] = '{3, 98,  28, 12'hDDD};
        tbl[21] = '{3, 0,   84, 12'hFFF};
        tbl[22] = '{3, 27,  84, 12'h555};
        tbl[23] = '{3, 145, 39, 12'hDDD};
        tbl[24] = '{3, 146, 39, 12'hFFF};
        // phase 5: restart then one tick -> gnd_off=2, cld_off=0
        tbl[25] = '{5, 126, 84, 12'h555};
        tbl[26] = '{5, 147, 28, 12'hDDD};
        tbl[27] = '{5, 0,   84, 12'hFFF};
        // phase 6: 512 ticks after restart -> gnd_off wrapped to 0
        tbl[28] = '{6, 0,   84, 12'h555};
        tbl[29] = '{6, 37,  84, 12'h555};
        tbl[30] = '{6, 1,   84, 12'hFFF};
        tbl[31] = '{6, 17,  90, 12'h555};

        rst_n = 1'b0; clk_100Hz = 1'b0; gs = 2'd1; x_i = '0; y_i = 9'd80;
        repeat (3) @(posedge clk);
        #1 check("reset_data", data, 12'hFFF);
        rst_n = 1'b1;

        run_phase(1);
        run_phase(2);
        do_ticks(5);
        run_phase(3);
        @(posedge clk); #1 gs = 2'd2;
        do_ticks(10);
        run_phase(3);
        @(posedge clk); #1 gs = 2'd0;
        do_ticks(3);
        run_phase(3);
        @(posedge clk); #1 gs = 2'd3;
        @(posedge clk); #1 gs = 2'd0;
        run_phase(2);
        @(posedge clk); #1 gs = 2'd1;
        do_ticks(1);
        run_phase(5);
        restart_pulse();
        do_ticks(512);
        run_phase(6);

        // asynchronous reset mid-frame must clear the pixel at once
        check_px(0, 80, 12'h555, "pre_async");
        rst_n = 1'b0;
        #1 check("async_reset", data, 12'hFFF);
        @(posedge clk); #1 rst_n = 1'b1;

        // raster sweep with 5-cycle tick period, counting ticks in the bench
        begin
            int  n = 0;
            bit  prev = 1'b0;
            int  gnd, cld, px;
            restart_pulse();
            for (int c = 0; c < 2000; c++) begin
                @(posedge clk); #1;
                if (c > 0 && !(data == 12'hFFF || data == 12'h555 || data == 12'hDDD))
                    check($sformatf("sweep_c%0d", c), data, 12'hFFF);
                else if (c > 0)
                    checks++;
                x_i = 10'(c % 640);
                y_i = 9'((c / 640) % 80 + 20);
                clk_100Hz = ((c % 5) < 3);
                if (clk_100Hz && !prev) n++;
                prev = clk_100Hz;
            end
            @(posedge clk); #1 clk_100Hz = 1'b0;
            repeat (6) @(posedge clk);
            #1 gs = 2'd0;
            gnd = (2 * n) % 1024;
            cld = (n / 2) % 1024;
            px  = (128 - (gnd % 128)) % 128;
            check_px(px,     84, 12'h555, "sweep_pebble");
            check_px(px + 1, 84, 12'hFFF, "sweep_pebble_next");
            px  = (500 - cld + 1024) % 1024;
            check_px(px,     44, 12'hDDD, "sweep_cloudb");
            check_px(px - 1, 44, 12'hFFF, "sweep_cloudb_prev");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
